// File: rtl/i2c_master_core.sv
// i2c_master_core: MMIO-mapped single-master I2C bus controller.
// Software sets a quarter-bit divisor, then issues one bus command at a time
// (START, WRITE, READ, STOP, RESTART) and polls status for ready/ack/rx_data.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   cs        chip select for register access
//   read      read strobe (no side effects)
//   write     write strobe; register write when cs & write on a clk edge
//   reg_addr  register select: 0 status (rd), 1 dvsr (wr), 2 command (wr)
//   wr_data   write data
//   rd_data   read data, combinational decode of reg_addr
//   scl       open-drain clock, drives 0 or Z
//   sda       open-drain data, drives 0 or Z, sampled as input
module i2c_master_core #(
    parameter logic [15:0] DVSR_RST = 16'd249
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output tri          scl,
    inout  tri          sda
);

    typedef enum logic [3:0] {
        StIdle, StHold, StStart1, StStart2, StRestart1, StRestart2,
        StData1, StData2, StData3, StData4, StDataEnd, StStop1, StStop2
    } state_e;

    localparam logic [2:0] CmdStart   = 3'd0;
    localparam logic [2:0] CmdWrite   = 3'd1;
    localparam logic [2:0] CmdRead    = 3'd2;
    localparam logic [2:0] CmdStop    = 3'd3;
    localparam logic [2:0] CmdRestart = 3'd4;

    state_e      state;
    logic [15:0] dvsr;
    logic [15:0] cnt;
    logic [1:0]  rep;       // extra phase count for 2Q / 4Q states
    logic [3:0]  bit_cnt;
    logic [7:0]  tx;        // bits still to send after the current one
    logic [8:0]  rx_shift;
    logic [7:0]  rx_data;
    logic        ack;
    logic        is_rd;
    logic        nack;
    logic        scl_rel;   // 1 = released (Z)
    logic        sda_rel;
    logic        ready;
    logic        tick;
    logic        cmd_wr;
    logic        dvsr_wr;
    logic [2:0]  cmd;
    logic        unused_ok;

    assign ready     = (state == StIdle) || (state == StHold);
    assign tick      = (cnt == dvsr);
    assign cmd       = wr_data[10:8];
    assign cmd_wr    = cs && write && (reg_addr == 5'd2) && ready;
    assign dvsr_wr   = cs && write && (reg_addr == 5'd1) && ready;
    assign unused_ok = ^{read, wr_data[31:16]};

    assign scl = scl_rel ? 1'bz : 1'b0;
    assign sda = sda_rel ? 1'bz : 1'b0;

    always_comb begin
        rd_data = 32'd0;
        if (reg_addr == 5'd0) begin
            rd_data = {22'd0, ready, ack, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            dvsr     <= DVSR_RST;
            cnt      <= 16'd0;
            rep      <= 2'd0;
            bit_cnt  <= 4'd0;
            tx       <= 8'd0;
            rx_shift <= 9'd0;
            rx_data  <= 8'd0;
            ack      <= 1'b0;
            is_rd    <= 1'b0;
            nack     <= 1'b0;
            scl_rel  <= 1'b1;
            sda_rel  <= 1'b1;
        end else begin
            if (dvsr_wr) begin
                dvsr <= wr_data[15:0];
            end
            if (ready || tick) begin
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
            case (state)
                StIdle: begin
                    if (cmd_wr && cmd == CmdStart) begin
                        state   <= StStart1;
                        sda_rel <= 1'b0;
                        scl_rel <= 1'b1;
                        rep     <= 2'd0;
                    end
                end
                StHold: begin
                    if (cmd_wr) begin
                        case (cmd)
                            CmdStart, CmdRestart: begin
                                state   <= StRestart1;
                                sda_rel <= 1'b1;
                            end
                            CmdWrite, CmdRead: begin
                                state   <= StData1;
                                bit_cnt <= 4'd0;
                                is_rd   <= (cmd == CmdRead);
                                nack    <= wr_data[0];
                                if (cmd == CmdWrite) begin
                                    sda_rel <= wr_data[7];
                                    tx      <= {wr_data[6:0], 1'b1};
                                end else begin
                                    sda_rel <= 1'b1;
                                    tx      <= {7'h7f, wr_data[0]};
                                end
                            end
                            CmdStop: begin
                                state   <= StStop1;
                                sda_rel <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                StStart1: begin
                    if (tick) begin
                        if (rep == 2'd1) begin
                            state   <= StStart2;
                            scl_rel <= 1'b0;
                            rep     <= 2'd0;
                        end else begin
                            rep <= rep + 2'd1;
                        end
                    end
                end
                StStart2: if (tick) state <= StHold;
                StRestart1: begin
                    if (tick) begin
                        state   <= StRestart2;
                        scl_rel <= 1'b1;
                    end
                end
                StRestart2: begin
                    if (tick) begin
                        state   <= StStart1;
                        sda_rel <= 1'b0;
                        rep     <= 2'd0;
                    end
                end
                StData1: begin
                    if (tick) begin
                        state   <= StData2;
                        scl_rel <= 1'b1;
                    end
                end
                StData2: if (tick) state <= StData3;
                StData3: begin
                    // Sample on the last cycle of the scl-high window.
                    if (tick) begin
                        state    <= StData4;
                        scl_rel  <= 1'b0;
                        rx_shift <= {rx_shift[7:0], sda};
                    end
                end
                StData4: begin
                    if (tick) begin
                        if (bit_cnt == 4'd8) begin
                            state <= StDataEnd;
                            if (is_rd) begin
                                rx_data <= rx_shift[8:1];
                                ack     <= nack;
                            end else begin
                                ack <= rx_shift[0];
                            end
                        end else begin
                            state   <= StData1;
                            bit_cnt <= bit_cnt + 4'd1;
                            sda_rel <= tx[7];
                            tx      <= {tx[6:0], 1'b1};
                        end
                    end
                end
                StDataEnd: if (tick) state <= StHold;
                StStop1: begin
                    if (tick) begin
                        state   <= StStop2;
                        scl_rel <= 1'b1;
                        rep     <= 2'd0;
                    end
                end
                StStop2: begin
                    // 4Q total: sda low for 2Q, then both lines high for 2Q.
                    if (tick) begin
                        rep <= rep + 2'd1;
                        if (rep == 2'd1) sda_rel <= 1'b1;
                        if (rep == 2'd3) state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
